// File: rtl/axis_frame_source_if.sv
// axis_frame_source_if: AXI4-Stream beat bus between the frame source (master) and its sink (slave).
// data_out: TDATA, lane k at [k*DATA_W +: DATA_W]; valid: TVALID; ready: TREADY;
// last_out: TLAST (final beat of a frame); user_out: TUSER (first beat of a frame).
interface axis_frame_source_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 1
);
  logic [LANES*DATA_W-1:0] data_out;
  logic                    valid;
  logic                    ready;
  logic                    last_out;
  logic                    user_out;
  modport master (output data_out, valid, last_out, user_out, input ready);
  modport slave  (input data_out, valid, last_out, user_out, output ready);
endinterface

// File: rtl/axis_frame_source.sv
// axis_frame_source: AXI4-Stream image-frame generator with SOF/EOF markers, selectable pattern, throttle and abort.
// clk/reset_n: clock, async active-low reset; start_in: run request (level, IDLE only); stop_in: abort;
// num_frames/mode/seed: run config latched at start; throttle: live gap rate; axis: stream master;
// busy: in RUN; done: in DONE; frames_sent: completed frames (saturating).
module axis_frame_source #(
  parameter int DATA_W = 8,
  parameter int LANES  = 1,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_in,
  input  logic                  stop_in,
  input  logic [CNT_W-1:0]      num_frames,
  input  logic [1:0]            mode,
  input  logic [DATA_W-1:0]     seed,
  input  logic [3:0]            throttle,
  axis_frame_source_if.master   axis,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      frames_sent
);
  localparam int XB = IMG_W / LANES;
  localparam int XW = XB > 1 ? $clog2(XB) : 1;
  localparam int YW = IMG_H > 1 ? $clog2(IMG_H) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                  r_state, w_state_nx;
  logic [XW-1:0]           r_x;
  logic [YW-1:0]           r_y;
  logic [CNT_W-1:0]        r_f, r_nf, r_sent;
  logic [1:0]              r_mode;
  logic [DATA_W-1:0]       r_seed;
  logic [3:0]              r_gap_cnt;
  logic                    r_valid, r_stop;
  logic [15:0]             r_lfsr, w_lfsr_nx;
  logic                    w_hs, w_x_end, w_y_end, w_eof, w_final, w_stop, w_gap;
  logic [LANES*DATA_W-1:0] w_data;
  function automatic logic [15:0] lfsr_init(input logic [DATA_W-1:0] s);
    return s == '0 ? 16'd1 : 16'(s);
  endfunction
  assign w_hs    = r_valid & axis.ready;
  assign w_x_end = r_x == XW'(XB - 1);
  assign w_y_end = r_y == YW'(IMG_H - 1);
  assign w_eof   = w_x_end & w_y_end;
  assign w_final = w_eof & (r_f == r_nf - 1'b1);
  assign w_stop  = r_stop | stop_in;
  // >= rather than == so a live drop of throttle below the running count still yields a gap
  assign w_gap   = (throttle != 4'd0) && (r_gap_cnt + 4'd1 >= throttle);
  // lane k sees the LFSR after k+1 steps; w_lfsr_nx is the state after all lanes of this beat
  always_comb begin
    logic [15:0] s;
    logic [31:0] p;
    w_data = '0;
    s = r_lfsr;
    for (int k = 0; k < LANES; k++) begin
      s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
      p = 32'(r_y) * 32'(IMG_W) + 32'(r_x) * 32'(LANES) + 32'(k) + (r_mode == 2'd1 ? 32'(r_f) : 32'd0);
      w_data[k*DATA_W +: DATA_W] = r_mode == 2'd3 ? s[DATA_W-1:0] : r_mode == 2'd2 ? r_seed : p[DATA_W-1:0];
    end
    w_lfsr_nx = s;
  end
  always_comb begin
    w_state_nx = r_state;
    w_state_nx = r_state == IDLE ? (start_in ? RUN : IDLE) :
                 r_state == RUN  ? (((w_hs && (w_final || w_stop)) || (!r_valid && w_stop)) ? DONE : RUN) :
                                   (start_in ? DONE : IDLE);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nx;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x       <= '0;
      r_y       <= '0;
      r_f       <= '0;
      r_nf      <= '0;
      r_sent    <= '0;
      r_mode    <= '0;
      r_seed    <= '0;
      r_gap_cnt <= '0;
      r_valid   <= 1'b0;
      r_stop    <= 1'b0;
      r_lfsr    <= '0;
    end else if (r_state == IDLE) begin
      if (start_in) begin
        r_x       <= '0;
        r_y       <= '0;
        r_f       <= '0;
        r_nf      <= num_frames == '0 ? CNT_W'(1) : num_frames;
        r_sent    <= '0;
        r_mode    <= mode;
        r_seed    <= seed;
        r_gap_cnt <= '0;
        r_valid   <= 1'b1;
        r_stop    <= 1'b0;
        r_lfsr    <= lfsr_init(seed);
      end
    end else if (r_state == RUN) begin
      r_stop <= w_stop;
      if (w_hs) begin
        r_x       <= w_x_end ? '0 : r_x + 1'b1;
        r_y       <= w_x_end ? (w_y_end ? '0 : r_y + 1'b1) : r_y;
        r_f       <= w_eof ? r_f + 1'b1 : r_f;
        r_lfsr    <= w_eof ? lfsr_init(r_seed) : w_lfsr_nx;
        r_sent    <= (w_eof && r_sent != '1) ? r_sent + 1'b1 : r_sent;
        r_gap_cnt <= w_gap ? '0 : r_gap_cnt + 4'd1;
        r_valid   <= !(w_final || w_stop || w_gap);
      end else if (!r_valid) begin
        r_valid <= !w_stop;
      end
    end
  end
  assign axis.valid    = r_valid;
  assign axis.data_out = r_valid ? w_data : '0;
  assign axis.user_out = r_valid & (r_x == '0) & (r_y == '0);
  assign axis.last_out = r_valid & w_eof;
  assign busy          = r_state == RUN;
  assign done          = r_state == DONE;
  assign frames_sent   = r_sent;
endmodule

// File: tb/tb_axis_frame_source.sv
// tb_axis_frame_source: table-driven and directed checks of axis_frame_source on a 4x2 and a 4-lane 8x2 instance.
module tb_axis_frame_source;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset_n, start_in, stop_in, b_start;
  logic [15:0] num_frames;
  logic [1:0]  mode;
  logic [7:0]  seed;
  logic [3:0]  throttle;
  logic        busy, done, b_busy, b_done;
  logic [15:0] frames_sent, b_fs;
  int checks = 0;
  int failures = 0;
  axis_frame_source_if #(.DATA_W(8), .LANES(1)) sa ();
  axis_frame_source_if #(.DATA_W(8), .LANES(4)) sb ();
  axis_frame_source #(.DATA_W(8), .LANES(1), .IMG_W(4), .IMG_H(2), .CNT_W(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .start_in(start_in), .stop_in(stop_in), .num_frames(num_frames),
    .mode(mode), .seed(seed), .throttle(throttle), .axis(sa), .busy(busy), .done(done),
    .frames_sent(frames_sent));
  axis_frame_source #(.DATA_W(8), .LANES(4), .IMG_W(8), .IMG_H(2), .CNT_W(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .start_in(b_start), .stop_in(stop_in), .num_frames(num_frames),
    .mode(mode), .seed(seed), .throttle(throttle), .axis(sb), .busy(b_busy), .done(b_done),
    .frames_sent(b_fs));
  typedef struct {
    logic st, sp, rd;
    logic [1:0] md;
    logic [15:0] nf;
    logic [7:0] sd;
    logic [3:0] th;
    logic v;
    logic [7:0] d;
    logic u, l, bz, dn;
    logic [15:0] fs;
  } vec_t;
  vec_t tv[$];
  logic [1:0] c_md;
  logic [15:0] c_nf;
  logic [7:0] c_sd;
  logic [3:0] c_th;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  function automatic void row(input logic st, sp, rd, v, input logic [7:0] d,
                              input logic u, l, bz, dn, input logic [15:0] fs);
    vec_t r;
    r.st = st; r.sp = sp; r.rd = rd; r.md = c_md; r.nf = c_nf; r.sd = c_sd; r.th = c_th;
    r.v = v; r.d = d; r.u = u; r.l = l; r.bz = bz; r.dn = dn; r.fs = fs;
    tv.push_back(r);
  endfunction
  function automatic logic [15:0] lstep(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction
  task automatic run_lfsr(input logic [7:0] sd, input logic [15:0] nf, input bit rnd);
    logic [15:0] s;
    logic [7:0] pd;
    logic pu, pl, stall;
    int beat, cyc, total;
    total = 8 * int'(nf == 0 ? 16'd1 : nf);
    @(negedge clk);
    mode = 2'd3; seed = sd; num_frames = nf; throttle = 4'd0; start_in = 1'b1; sa.ready = 1'b0;
    @(negedge clk);
    start_in = 1'b0;
    beat = 0; cyc = 0; stall = 1'b0; s = 16'd1; pd = '0; pu = 1'b0; pl = 1'b0;
    while (beat < total && cyc < 400) begin
      sa.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (stall) chk("hold", {sa.valid, sa.data_out, sa.user_out, sa.last_out}, {1'b1, pd, pu, pl});
      pd = sa.data_out; pu = sa.user_out; pl = sa.last_out;
      stall = sa.valid && !sa.ready;
      if (sa.valid && sa.ready) begin
        if (beat % 8 == 0) s = (sd == 8'd0) ? 16'h0001 : {8'h00, sd};
        s = lstep(s);
        chk($sformatf("lfsr_seed%h_beat%0d", sd, beat), {sa.data_out, sa.user_out, sa.last_out},
            {s[7:0], beat % 8 == 0, beat % 8 == 7});
        beat++;
      end
      cyc++;
      @(negedge clk);
    end
    #1;
    chk("lfsr_beats", 64'(beat), 64'(total));
    chk("lfsr_done_fs", {done, frames_sent}, {1'b1, 16'(total / 8)});
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    reset_n = 1'b0; start_in = 1'b0; stop_in = 1'b0; b_start = 1'b0;
    num_frames = '0; mode = '0; seed = '0; throttle = '0; sa.ready = 1'b0; sb.ready = 1'b0;
    // S1: plain ramp, one frame
    c_md = 2'd0; c_nf = 16'd1; c_sd = 8'd0; c_th = 4'd0;
    row(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) row(0, 0, 1, 1, 8'(i), i == 0, i == 7, 1, 0, 0);
    row(0, 0, 1, 0, 0, 0, 0, 0, 1, 1);
    row(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    // S2: throttle 3 gives 1,1,1,0 valid pattern
    c_th = 4'd3;
    row(1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      row(0, 0, 1, 1, 8'(i), i == 0, i == 7, 1, 0, 0);
      if (i % 3 == 2) row(0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    end
    row(0, 0, 1, 0, 0, 0, 0, 0, 1, 1);
    row(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    // S3: abort on a stalled beat 5 holds it until accepted
    c_th = 4'd0; c_nf = 16'd2;
    row(1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) row(0, 0, 1, 1, 8'(i), i == 0, 0, 1, 0, 0);
    row(0, 1, 0, 1, 8'd5, 0, 0, 1, 0, 0);
    row(0, 0, 0, 1, 8'd5, 0, 0, 1, 0, 0);
    row(0, 0, 1, 1, 8'd5, 0, 0, 1, 0, 0);
    row(0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    row(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    // S4: abort during a throttle gap ends next cycle
    c_th = 4'd2; c_nf = 16'd1;
    row(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    row(0, 0, 1, 1, 8'd0, 1, 0, 1, 0, 0);
    row(0, 0, 1, 1, 8'd1, 0, 0, 1, 0, 0);
    row(0, 1, 1, 0, 0, 0, 0, 1, 0, 0);
    row(0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    row(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    // S5: frame-offset ramp over two frames
    c_th = 4'd0; c_md = 2'd1; c_nf = 16'd2;
    row(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 8; i++) row(0, 0, 1, 1, 8'(i + f), i == 0, i == 7, 1, 0, 16'(f));
    row(0, 0, 1, 0, 0, 0, 0, 0, 1, 2);
    row(0, 0, 1, 0, 0, 0, 0, 0, 0, 2);
    // S6: constant seed, num_frames=0 sends one frame
    c_md = 2'd2; c_nf = 16'd0; c_sd = 8'h3C;
    row(1, 0, 1, 0, 0, 0, 0, 0, 0, 2);
    for (int i = 0; i < 8; i++) row(0, 0, 1, 1, 8'h3C, i == 0, i == 7, 1, 0, 0);
    row(0, 0, 1, 0, 0, 0, 0, 0, 1, 1);
    row(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("reset_a", {sa.valid, sa.data_out, sa.user_out, sa.last_out, busy, done, frames_sent}, '0);
    chk("reset_b", {sb.valid, sb.data_out, sb.user_out, sb.last_out, b_busy, b_done, b_fs}, '0);
    @(negedge clk);
    reset_n = 1'b1;
    foreach (tv[i]) begin
      @(negedge clk);
      start_in = tv[i].st; stop_in = tv[i].sp; sa.ready = tv[i].rd;
      mode = tv[i].md; num_frames = tv[i].nf; seed = tv[i].sd; throttle = tv[i].th;
      #1;
      chk($sformatf("vec%0d", i), {sa.valid, sa.data_out, sa.user_out, sa.last_out, busy, done, frames_sent},
          {tv[i].v, tv[i].d, tv[i].u, tv[i].l, tv[i].bz, tv[i].dn, tv[i].fs});
    end
    start_in = 1'b0; stop_in = 1'b0;
    // LFSR with random ready, then zero seed
    run_lfsr(8'hA5, 16'd2, 1'b1);
    run_lfsr(8'h00, 16'd1, 1'b0);
    // 4-lane instance, frame-offset ramp over two frames
    begin
      int beat, cyc, f, x, y;
      logic [31:0] e;
      @(negedge clk);
      mode = 2'd1; num_frames = 16'd2; throttle = 4'd0; sb.ready = 1'b1; b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      beat = 0; cyc = 0;
      while (!b_done && cyc < 100) begin
        #1;
        if (sb.valid) begin
          f = beat / 4; x = beat % 2; y = (beat % 4) / 2;
          for (int k = 0; k < 4; k++) e[k*8 +: 8] = 8'(y * 8 + x * 4 + k + f);
          chk($sformatf("b_beat%0d", beat), {sb.data_out, sb.user_out, sb.last_out},
              {e, beat % 4 == 0, beat % 4 == 3});
          if (beat == 4) chk("b_f1_beat0", 64'(sb.data_out), 64'h04030201);
          beat++;
        end
        cyc++;
        @(negedge clk);
      end
      #1;
      chk("b_beats", 64'(beat), 64'd8);
      chk("b_done_fs", {b_done, b_fs}, {1'b1, 16'd2});
    end
    // async reset mid-frame, then restart with num_frames=0
    begin
      int beat, cyc;
      @(negedge clk);
      mode = 2'd0; num_frames = 16'd0; throttle = 4'd0; sa.ready = 1'b1; start_in = 1'b1;
      @(negedge clk);
      start_in = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("pre_reset_beat", {sa.valid, sa.data_out}, {1'b1, 8'd2});
      #1;
      reset_n = 1'b0;
      #1;
      chk("async_reset", {sa.valid, sa.data_out, sa.user_out, sa.last_out, busy, done, frames_sent}, '0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      start_in = 1'b1;
      @(negedge clk);
      start_in = 1'b0;
      #1;
      chk("restart_first", {sa.valid, sa.data_out, sa.user_out}, {1'b1, 8'd0, 1'b1});
      beat = 0; cyc = 0;
      while (!done && cyc < 100) begin
        if (sa.valid) beat++;
        cyc++;
        @(negedge clk);
        #1;
      end
      chk("nf0_one_frame", {64'(beat)}, 64'd8);
      chk("nf0_fs", {done, frames_sent}, {1'b1, 16'd1});
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axis_frame_source.md
Name: axis_frame_source

Overview:
- Parametrised AXI4-Stream image-frame generator; next generation of the single-lane byte `instream` test source used in the HLS-target benches.
- Emits `num_frames` frames of IMG_W x IMG_H pixels, LANES pixels per beat.
- Provides start-of-frame (TUSER) and end-of-frame (TLAST) markers, a selectable data pattern, optional valid throttling and clean abort.
- Sits between the config/start sequencer and the DUT stream input, in simulation and on FPGA self-test builds.

Parameters:
- DATA_W, 8: bits per pixel.
- LANES, 1: pixels per beat. IMG_W must be a multiple of LANES.
- IMG_W, 64: pixels per line.
- IMG_H, 64: lines per frame.
- CNT_W, 16: width of the frame counters.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start_in  in  1  level; sampled only in IDLE.
- stop_in  in  1  abort request; sticky internally until DONE.
- num_frames  in  CNT_W  frames to send. Latched at start; 0 is treated as 1.
- mode  in  2  pattern select, latched at start: 0 ramp, 1 frame-offset ramp, 2 constant seed, 3 LFSR.
- seed  in  DATA_W  constant value in mode 2, LFSR seed in mode 3. Latched at start.
- throttle  in  4  0 = no gaps; N>0 = one idle cycle after every N accepted beats. Sampled live.
- data_out  out  LANES*DATA_W  TDATA. Lane k occupies bits [k*DATA_W +: DATA_W].
- valid  out  1  TVALID.
- ready  in  1  TREADY.
- last_out  out  1  TLAST; high on the final beat of each frame.
- user_out  out  1  TUSER; high on the first beat of each frame.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- frames_sent  out  CNT_W  count of fully completed frames.

Behaviour:
- Reset (async assert, sync deassert):
  - valid, last_out, user_out, busy, done = 0; data_out = 0; frames_sent = 0; state = IDLE.
- States:
  - IDLE -> RUN when start_in=1: latch num_frames/mode/seed, clear counters and frames_sent, clear stop flag.
  - RUN -> DONE after the last beat of the final frame is accepted, or after an abort (see below).
  - DONE -> IDLE when start_in=0. done=1 throughout DONE.
- Beat counters:
  - x_beat 0..IMG_W/LANES-1, y 0..IMG_H-1, frame f.
  - Advance only on handshake (valid & ready). Wrap x -> y -> f.
- Latency: valid rises the cycle after the start_in sample, with the first beat presented.
- Handshake rules:
  - Once valid=1, data_out/last_out/user_out hold stable until ready=1 (AXI rule).
  - valid never drops without a handshake.
  - ready high while valid=0 has no effect.
- Pixel value, with p = y*IMG_W + x_beat*LANES + k (lane k):
  - mode 0: p mod 2^DATA_W.
  - mode 1: (p + f) mod 2^DATA_W.
  - mode 2: seed on every lane.
  - mode 3: 16-bit Fibonacci LFSR, taps 16,14,13,11. Initialised to {8'h00… zero-extended seed}; a zero seed is forced to 1. Advances once per lane per handshake; lane k = low DATA_W bits after k+1 steps. Restarts at each frame.
- Markers:
  - user_out = (x_beat==0 && y==0).
  - last_out = (x_beat==last && y==IMG_H-1).
  - With a 1-beat frame, both are high on the same beat.
- Throttle:
  - After each N handshakes, valid=0 for exactly one cycle, then resumes.
  - A gap never splits an in-flight (valid=1, ready=0) beat.
  - The gap counter resets at start.
- Abort (stop_in, any cycle in RUN):
  - If valid=1 and not yet accepted, hold that beat until its handshake, then go to DONE.
  - If valid=0, go to DONE next cycle.
  - frames_sent counts only frames whose last_out beat was accepted.
  - stop_in in IDLE or DONE is ignored.
- frames_sent increments on the last_out handshake. It saturates at 2^CNT_W-1.
- Async reset mid-frame: all outputs return to reset values immediately; no partial beat is held.

Test Plan:
1. DATA_W=8, LANES=1, 4x2, num_frames=1, mode 0, ready=1, throttle=0 -> 8 consecutive beats 0..7; user_out on beat 0; last_out on beat 7; done=1; frames_sent=1.
2. LANES=4, IMG_W=8, IMG_H=2, mode 1, num_frames=2 -> frame 1 beat 0 data_out = {8'h04,8'h03,8'h02,8'h01}; 8 beats total; frames_sent=2.
3. Random ready (50%), mode 3, seed=8'hA5 -> data/last/user stable across every stall; pixel stream matches the reference LFSR model; zero seed yields the nonzero sequence from 1.
4. throttle=3, ready=1 -> valid pattern 1,1,1,0 repeating; beat count per frame unchanged.
5. stop_in pulsed while valid=1 and ready=0 on beat 5 of frame 0 -> beat 5 held until ready, then DONE; no beat 6; frames_sent=0.
6. reset_n low mid-frame -> outputs 0 in the same cycle; a new start_in restarts at pixel 0 with user_out=1. num_frames=0 -> exactly one frame.
